// File: rtl/local_hist_branch_predictor.sv
// Two-level local-history branch predictor with post-reset table sweep.
// Define BP_GSHARE_EN to XOR branch PC bits into the PHT index.
module local_hist_branch_predictor #(
  parameter int ADDR_W       = 32,
  parameter int LHT_IDX_BITS = 3,
  parameter int HIST_BITS    = 3,
  parameter int CTR_BITS     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lookup_valid,
  input  logic [ADDR_W-1:0] lookup_pc,
  input  logic [ADDR_W-1:0] lookup_offset,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  output logic              init_done
);

  localparam int LHT_N = 1 << LHT_IDX_BITS;
  localparam int PHT_N = 1 << HIST_BITS;
  localparam int SWP_N = (LHT_N > PHT_N) ? LHT_N : PHT_N;
  localparam int CNT_W =
    (LHT_IDX_BITS > HIST_BITS) ? LHT_IDX_BITS : HIST_BITS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SWP_N - 1);
  localparam logic [CTR_BITS-1:0] CTR_WNT =
    {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  typedef enum logic {INIT, RUN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             init_done_q, init_done_d;
  logic             pv_q, pt_q;
  logic [ADDR_W-1:0] tgt_q;

  logic [HIST_BITS-1:0] lht_q [LHT_N];
  logic [CTR_BITS-1:0]  pht_q [PHT_N];

  logic [LHT_IDX_BITS-1:0] lk_lidx, up_lidx;
  logic [HIST_BITS-1:0]    lk_hist, up_hist;
  logic [HIST_BITS-1:0]    lk_pidx, up_pidx;
  logic [HIST_BITS-1:0]    lht_nxt;
  logic [CTR_BITS-1:0]     lk_ctr, up_ctr, up_ctr_nxt;
  logic                    unused_ok;

  assign lk_lidx = lookup_pc[LHT_IDX_BITS+1:2];
  assign up_lidx = upd_pc[LHT_IDX_BITS+1:2];
  assign lk_hist = lht_q[lk_lidx];
  assign up_hist = lht_q[up_lidx];

`ifdef BP_GSHARE_EN
  assign lk_pidx = lk_hist ^ lookup_pc[HIST_BITS+1:2];
  assign up_pidx = up_hist ^ upd_pc[HIST_BITS+1:2];
`else
  assign lk_pidx = lk_hist;
  assign up_pidx = up_hist;
`endif

  assign lk_ctr = pht_q[lk_pidx];
  assign up_ctr = pht_q[up_pidx];

  assign unused_ok = ^{lookup_pc, upd_pc, lk_ctr};

  always_comb begin
    up_ctr_nxt = up_ctr;
    if (upd_taken && up_ctr != CTR_MAX)
      up_ctr_nxt = up_ctr + CTR_BITS'(1);
    else if (!upd_taken && up_ctr != '0)
      up_ctr_nxt = up_ctr - CTR_BITS'(1);
  end

  // newest outcome enters at the MSB
  always_comb begin
    lht_nxt = up_hist >> 1;
    lht_nxt[HIST_BITS-1] = upd_taken;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    unique case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d     = RUN;
          cnt_d       = '0;
          init_done_d = 1'b1;
        end
      end
      RUN: ;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      pv_q        <= 1'b0;
      pt_q        <= 1'b0;
      tgt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      if (state_q == RUN && lookup_valid) begin
        pv_q  <= 1'b1;
        pt_q  <= lk_ctr[CTR_BITS-1];
        tgt_q <= lookup_pc + lookup_offset;
      end else begin
        pv_q <= 1'b0;
        pt_q <= 1'b0;
      end
    end
  end

  // tables are not reset; the INIT sweep clears them
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      if (int'(cnt_q) < LHT_N)
        lht_q[cnt_q[LHT_IDX_BITS-1:0]] <= '0;
      if (int'(cnt_q) < PHT_N)
        pht_q[cnt_q[HIST_BITS-1:0]] <= CTR_WNT;
    end else if (upd_valid) begin
      lht_q[up_lidx] <= lht_nxt;
      pht_q[up_pidx] <= up_ctr_nxt;
    end
  end

  assign pred_valid  = pv_q;
  assign pred_taken  = pt_q;
  assign pred_target = tgt_q;
  assign init_done   = init_done_q;

endmodule

// File: tb/tb_local_hist_branch_predictor.sv
// Directed bench for local_hist_branch_predictor (default build).
// Expected values are hand-derived from table traces.
module tb_local_hist_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic [31:0] lookup_offset;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        init_done;

  int n_chk;
  int n_fail;

  local_hist_branch_predictor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lookup_valid (lookup_valid),
    .lookup_pc    (lookup_pc),
    .lookup_offset(lookup_offset),
    .pred_valid   (pred_valid),
    .pred_taken   (pred_taken),
    .pred_target  (pred_target),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_taken    (upd_taken),
    .init_done    (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lk(input logic v, input logic [31:0] pc);
    lookup_valid = v;
    lookup_pc    = pc;
  endtask

  task automatic up(input logic v, input logic [31:0] pc,
                    input logic t);
    upd_valid = v;
    upd_pc    = pc;
    upd_taken = t;
  endtask

  task automatic sweep(input string tag);
    for (int e = 1; e <= 7; e++) begin
      step();
      chk({tag, "_done_lo"}, init_done, 0);
      chk({tag, "_pv_lo"}, pred_valid, 0);
    end
    step();
    chk({tag, "_done_8"}, init_done, 1);
    chk({tag, "_pv_8"}, pred_valid, 0);
    step();
    chk({tag, "_pv_9"}, pred_valid, 1);
    chk({tag, "_pt_9"}, pred_taken, 0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    lookup_offset = 32'h20;
    lk(0, 32'h0);
    up(0, 32'h0, 0);
    repeat (3) step();
    chk("rst_pv", pred_valid, 0);
    chk("rst_pt", pred_taken, 0);
    chk("rst_tgt", pred_target, 0);
    chk("rst_done", init_done, 0);

    lk(1, 32'h100);
    rst_n = 1'b1;
    sweep("init");
    chk("tgt_120", pred_target, 32'h120);

    lk(1, 32'hFFFF_FFF0);
    step();
    chk("wrap_pv", pred_valid, 1);
    chk("wrap_tgt", pred_target, 32'h10);

    lk(0, 32'h100);
    step();
    chk("idle_pv", pred_valid, 0);
    chk("idle_pt", pred_taken, 0);
    chk("idle_tgt", pred_target, 32'h10);

    // same-edge lookup and update: old counter seen
    lk(1, 32'h100);
    up(1, 32'h100, 1);
    step();
    chk("rbw_pv", pred_valid, 1);
    chk("rbw_pt", pred_taken, 0);
    up(0, 32'h0, 0);
    step();
    chk("lht100_pt", pred_taken, 0);
    lk(1, 32'h104);
    step();
    chk("shared_pt", pred_taken, 1);
    chk("shared_tgt", pred_target, 32'h124);

    lk(0, 32'h0);
    up(1, 32'h100, 1);
    repeat (5) step();
    up(0, 32'h0, 0);
    lk(1, 32'h100);
    step();
    chk("trained_pt", pred_taken, 1);

    lk(0, 32'h0);
    up(1, 32'h100, 0);
    step();
    up(0, 32'h0, 0);
    lk(1, 32'h100);
    step();
    chk("nt_pht3_pt", pred_taken, 0);
    lk(1, 32'h104);
    step();
    chk("pht0_still", pred_taken, 1);

    // drive PHT[0] to 00 and past; then climb back to 10
    lk(0, 32'h0);
    up(1, 32'h108, 0);
    repeat (3) step();
    up(0, 32'h0, 0);
    lk(1, 32'h104);
    step();
    chk("sat0_pt", pred_taken, 0);
    lk(0, 32'h0);
    up(1, 32'h10C, 1);
    step();
    up(1, 32'h110, 1);
    step();
    up(0, 32'h0, 0);
    lk(1, 32'h104);
    step();
    chk("climb_pt", pred_taken, 1);
    chk("climb_pv", pred_valid, 1);

    rst_n = 1'b0;
    #1;
    chk("async_pv", pred_valid, 0);
    chk("async_pt", pred_taken, 0);
    chk("async_done", init_done, 0);
    repeat (2) step();
    lk(1, 32'h100);
    rst_n = 1'b1;
    sweep("reinit");
    lk(1, 32'h104);
    step();
    chk("lost_pt", pred_taken, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
